reg_status_table: RTL and testbench
===================================

# reg_status_table

Parametrised register status table for the Tomasulo-style issue path. It tracks, per architectural register, whether a result is pending and which reservation-station tag will produce it. Dispatch marks a destination busy with its tag. Writeback clears entries by tag broadcast over several CDB ports. Source lookup ports return current status with same-cycle writeback bypass. It sits between dispatch and the reservation stations and replaces the single-port, index-cleared status table.

## Interface
Parameters:
- NREGS, 32, number of architectural registers (≥2).
- TAG_W, 4, producer tag width.
- NWB, 2, number of writeback/CDB broadcast ports (≥1).
- NSRC, 2, number of source lookup ports (≥1).
- ZERO_REG, 1, if 1 then register 0 never becomes busy.
- Derived: IDX_W = $clog2(NREGS), CNT_W = $clog2(NREGS+1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  clear the whole table (mispredict/exception recovery).
- di_write  in  1  dispatch writes a destination this cycle.
- di_sel  in  IDX_W  destination register index.
- di_tag  in  TAG_W  producer tag for di_sel.
- wb_valid  in  NWB  per-port writeback valid.
- wb_tag  in  NWB*TAG_W  per-port completing tag; port k occupies bits [k*TAG_W +: TAG_W].
- rd_sel  in  NSRC*IDX_W  lookup register indices, packed the same way.
- rd_busy  out  NSRC  lookup result: operand still pending.
- rd_tag  out  NSRC*TAG_W  lookup result: producer tag. It is '0 when rd_busy=0.
- busy_vec  out  NREGS  registered busy bit per register.
- busy_count  out  CNT_W  registered count of busy entries.

## Operation
- State per entry: busy (1b) and tag (TAG_W). On reset, every busy and tag is 0, busy_vec=0 and busy_count=0.
- Next-state priority per entry i, highest first:
  - flush: busy=0, tag=0 for all entries. Same-cycle dispatch and writebacks are discarded.
  - dispatch: if di_write && di_sel==i && !(ZERO_REG && i==0), then busy=1 and tag=di_tag. This wins over a same-cycle writeback match on entry i, because the new producer supersedes the old one.
  - writeback: if busy[i] and any k has wb_valid[k] && wb_tag[k]==tag[i] (current registered tag), then busy=0 and tag=0.
  - otherwise: hold.
- Writeback is by tag match, not by index. One broadcast may clear several entries. An older producer's completion does not clear an entry that has since been re-dispatched with a newer tag.
- A wb_tag matching no busy entry has no effect. A wb_tag matching on several ports is the same as matching on one.
- Lookups are combinational from the registered state plus bypass, for each port j with s = rd_sel[j]:
  - rd_busy[j] = busy[s] && !(any k: wb_valid[k] && wb_tag[k]==tag[s]).
  - rd_tag[j] = rd_busy[j] ? tag[s] : '0.
  - Lookups ignore same-cycle dispatch and flush, so a source that equals the same instruction's destination sees the old producer.
- ZERO_REG=1: dispatch to register 0 is dropped. rd_busy for index 0 is always 0.
- busy_count is updated on the same edge as the table and always equals the popcount of busy_vec.
- di_sel ≥ NREGS is ignored; there is no state change.

## Timing
- Dispatch to busy_vec/lookup visibility: 1 cycle. The entry is visible on the rising edge after di_write.
- Writeback to lookup: 0 cycles, via bypass. Writeback to busy_vec/busy_count: 1 cycle.
- flush takes effect on the next rising edge. Asserting nRST mid-operation clears all state immediately, without waiting for CLK.
- No handshake: every input is sampled every cycle and the table never stalls.

## Test plan
- Reset, then dispatch r5 with tag 3. Next cycle: busy_vec[5]=1, busy_count=1, lookup of r5 gives busy=1, tag=3.
- Dispatch r2 and r7 with tag 6 in successive cycles, then wb_valid[1]=1 with wb_tag=6. Same cycle: both lookups report busy=0. Next cycle: busy_vec[2]=busy_vec[7]=0 and busy_count drops by 2.
- WAW: r4 tag 1, then r4 tag 2, then writeback tag 1. r4 stays busy with tag 2.
- Dispatch r9 tag 5 in the same cycle as writeback tag 4, where r9 currently holds tag 4. Next cycle: r9 is busy with tag 5. A same-cycle lookup of r9 shows busy=0 through the bypass.
- ZERO_REG=1: dispatch r0 tag 7. r0 never becomes busy and busy_count is unchanged.
- Fill 10 entries, then assert flush together with a dispatch of r1. Next cycle: busy_vec=0 and busy_count=0. Separately, assert nRST low mid-run: outputs clear asynchronously.

Source files
------------

// File: rtl/reg_status_table_if.sv
// Bus bundle between dispatch/reader logic and the register status table.
// The master side drives dispatch, writeback and lookup requests; the table is the slave.
interface reg_status_table_if #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NWB   = 2,
    parameter int unsigned NSRC  = 2
);
    localparam int unsigned IDX_W = $clog2(NREGS);
    localparam int unsigned CNT_W = $clog2(NREGS + 1);

    logic                    flush;
    logic                    di_write;
    logic [IDX_W-1:0]        di_sel;
    logic [TAG_W-1:0]        di_tag;
    logic [NWB-1:0]          wb_valid;
    logic [NWB*TAG_W-1:0]    wb_tag;
    logic [NSRC*IDX_W-1:0]   rd_sel;
    logic [NSRC-1:0]         rd_busy;
    logic [NSRC*TAG_W-1:0]   rd_tag;
    logic [NREGS-1:0]        busy_vec;
    logic [CNT_W-1:0]        busy_count;

    modport master (
        output flush, di_write, di_sel, di_tag, wb_valid, wb_tag, rd_sel,
        input  rd_busy, rd_tag, busy_vec, busy_count
    );

    modport slave (
        input  flush, di_write, di_sel, di_tag, wb_valid, wb_tag, rd_sel,
        output rd_busy, rd_tag, busy_vec, busy_count
    );
endinterface

// File: rtl/reg_status_table.sv
// Register status table: per-register busy/producer-tag tracking with tag-broadcast
// writeback over several CDB ports and bypassed multi-port source lookups.
module reg_status_table #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned NWB      = 2,
    parameter int unsigned NSRC     = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    reg_status_table_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREGS);
    localparam int unsigned CNT_W = $clog2(NREGS + 1);
    // Lookup space padded to a power of two so any rd_sel value indexes safely.
    localparam int unsigned NPAD  = 1 << IDX_W;

    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [TAG_W-1:0]      tag_q [NREGS];
    logic [TAG_W-1:0]      tag_d [NREGS];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic [NREGS-1:0]      wb_hit;
    logic [NREGS-1:0]      di_hit;
    logic [NPAD-1:0]       look_busy;
    logic [TAG_W-1:0]      look_tag [NPAD];
    logic [IDX_W-1:0]      sel;
    logic [NSRC-1:0]       rd_busy_c;
    logic [NSRC*TAG_W-1:0] rd_tag_c;

    // Any valid CDB port broadcasting the tag currently held by an entry.
    always_comb begin
        wb_hit = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            for (int unsigned k = 0; k < NWB; k++) begin
                if (bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == tag_q[i])) begin
                    wb_hit[i] = 1'b1;
                end
            end
        end
    end

    // Dispatch decode; out-of-range indices decode to nothing.
    always_comb begin
        di_hit = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (bus.di_write && (bus.di_sel == IDX_W'(i)) && !(ZERO_REG && (i == 0))) begin
                di_hit[i] = 1'b1;
            end
        end
    end

    // Next state: flush, then dispatch (newer producer), then writeback clear.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (bus.flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end else if (di_hit[i]) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.di_tag;
            end else if (busy_q[i] && wb_hit[i]) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Bypassed view of the table: a same-cycle broadcast already reads as not busy.
    always_comb begin
        look_busy = '0;
        for (int unsigned i = 0; i < NPAD; i++) begin
            look_tag[i] = '0;
        end
        for (int unsigned i = 0; i < NREGS; i++) begin
            look_busy[i] = busy_q[i] && !wb_hit[i];
            look_tag[i]  = look_busy[i] ? tag_q[i] : '0;
        end
    end

    always_comb begin
        sel       = '0;
        rd_busy_c = '0;
        rd_tag_c  = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            sel                         = bus.rd_sel[j*IDX_W +: IDX_W];
            rd_busy_c[j]                = look_busy[sel];
            rd_tag_c[j*TAG_W +: TAG_W]  = look_tag[sel];
        end
    end

    assign bus.rd_busy    = rd_busy_c;
    assign bus.rd_tag     = rd_tag_c;
    assign bus.busy_vec   = busy_q;
    assign bus.busy_count = cnt_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Directed bench for reg_status_table: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_status_table;
    localparam int unsigned NREGS = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NWB   = 2;
    localparam int unsigned NSRC  = 2;

    localparam logic [1:0] K_VEC  = 2'd0;
    localparam logic [1:0] K_CNT  = 2'd1;
    localparam logic [1:0] K_BUSY = 2'd2;
    localparam logic [1:0] K_TAG  = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_status_table_if #(.NREGS(NREGS), .TAG_W(TAG_W), .NWB(NWB), .NSRC(NSRC)) bus ();

    reg_status_table #(
        .NREGS(NREGS), .TAG_W(TAG_W), .NWB(NWB), .NSRC(NSRC), .ZERO_REG(1'b1)
    ) u_dut (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  kind;
        logic [7:0]  port;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(logic [1:0] kind, int port);
        case (kind)
            K_VEC:   return 32'(bus.busy_vec);
            K_CNT:   return 32'(bus.busy_count);
            K_BUSY:  return 32'(bus.rd_busy[port]);
            default: return 32'(bus.rd_tag[port*TAG_W +: TAG_W]);
        endcase
    endfunction

    // Scoreboard monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc == cyc) begin
                act = actual(exp_q[i].kind, int'(exp_q[i].port));
                checks++;
                if (act !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                             name_q[i], cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
                name_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled", name_q[i], exp_q[i].cyc);
                exp_q.delete(i);
                name_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push_exp(string nm, logic [1:0] kind, int port, int dcyc, logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + dcyc;
        e.kind = kind;
        e.port = 8'(port);
        e.val  = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.di_write = 1'b0;
        bus.di_sel   = '0;
        bus.di_tag   = '0;
        bus.wb_valid = '0;
        bus.wb_tag   = '0;
    endtask

    task automatic disp(int sel, int tag);
        bus.di_write = 1'b1;
        bus.di_sel   = 5'(sel);
        bus.di_tag   = 4'(tag);
    endtask

    task automatic wb(int v, int t0, int t1);
        bus.wb_valid = 2'(v);
        bus.wb_tag   = {4'(t1), 4'(t0)};
    endtask

    task automatic rd(int s0, int s1);
        bus.rd_sel = {5'(s1), 5'(s0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        rd(0, 0);
        step();
        step();
        push_exp("reset busy_vec", K_VEC, 0, 0, 32'h0);
        push_exp("reset busy_count", K_CNT, 0, 0, 32'd0);
        push_exp("reset rd_busy0", K_BUSY, 0, 0, 32'd0);
        push_exp("reset rd_tag0", K_TAG, 0, 0, 32'd0);
        step();
        rst_n = 1'b1;

        // r5 <- tag 3, visible one cycle later
        step(); idle(); disp(5, 3); rd(5, 0);
        push_exp("r5 same-cycle lookup busy", K_BUSY, 0, 0, 32'd0);
        push_exp("r5 busy_vec", K_VEC, 0, 1, 32'h20);
        push_exp("r5 busy_count", K_CNT, 0, 1, 32'd1);
        step(); idle();
        push_exp("r5 lookup busy", K_BUSY, 0, 0, 32'd1);
        push_exp("r5 lookup tag", K_TAG, 0, 0, 32'd3);

        // r2, r7 share tag 6; one broadcast clears both
        step(); idle(); disp(2, 6);
        step(); idle(); disp(7, 6);
        step(); idle(); wb(2, 0, 6); rd(2, 7);
        push_exp("pre-wb busy_vec", K_VEC, 0, 0, 32'hA4);
        push_exp("pre-wb busy_count", K_CNT, 0, 0, 32'd3);
        push_exp("bypass r2 busy", K_BUSY, 0, 0, 32'd0);
        push_exp("bypass r7 busy", K_BUSY, 1, 0, 32'd0);
        push_exp("bypass r7 tag", K_TAG, 1, 0, 32'd0);
        push_exp("post-wb busy_vec", K_VEC, 0, 1, 32'h20);
        push_exp("post-wb busy_count", K_CNT, 0, 1, 32'd1);

        // WAW: stale completion of tag 1 leaves r4 on tag 2
        step(); idle(); disp(4, 1);
        step(); idle(); disp(4, 2);
        step(); idle(); wb(1, 1, 0); rd(4, 0);
        push_exp("waw bypass r4 busy", K_BUSY, 0, 0, 32'd1);
        push_exp("waw bypass r4 tag", K_TAG, 0, 0, 32'd2);
        push_exp("waw busy_vec", K_VEC, 0, 1, 32'h30);
        push_exp("waw busy_count", K_CNT, 0, 1, 32'd2);
        step(); idle();
        push_exp("waw r4 busy", K_BUSY, 0, 0, 32'd1);
        push_exp("waw r4 tag", K_TAG, 0, 0, 32'd2);

        // dispatch beats same-cycle writeback of the old tag
        step(); idle(); disp(9, 4);
        step(); idle(); disp(9, 5); wb(1, 4, 0); rd(4, 9);
        push_exp("r9 bypass busy", K_BUSY, 1, 0, 32'd0);
        push_exp("r9 bypass tag", K_TAG, 1, 0, 32'd0);
        push_exp("r9 busy_vec", K_VEC, 0, 1, 32'h230);
        push_exp("r9 busy_count", K_CNT, 0, 1, 32'd3);
        step(); idle();
        push_exp("r9 new busy", K_BUSY, 1, 0, 32'd1);
        push_exp("r9 new tag", K_TAG, 1, 0, 32'd5);

        // register 0 never becomes busy
        step(); idle(); disp(0, 7); rd(0, 9);
        push_exp("r0 busy_vec", K_VEC, 0, 1, 32'h230);
        push_exp("r0 busy_count", K_CNT, 0, 1, 32'd3);
        step(); idle();
        push_exp("r0 lookup busy", K_BUSY, 0, 0, 32'd0);
        push_exp("r0 lookup tag", K_TAG, 0, 0, 32'd0);

        // same tag on both CDB ports
        step(); idle(); wb(3, 5, 5);
        push_exp("dual wb r9 bypass", K_BUSY, 1, 0, 32'd0);
        push_exp("dual wb busy_vec", K_VEC, 0, 1, 32'h30);
        push_exp("dual wb busy_count", K_CNT, 0, 1, 32'd2);

        // fill r10..r19, then flush with a competing dispatch
        for (int r = 10; r < 20; r++) begin
            step(); idle(); disp(r, 8);
        end
        push_exp("fill busy_vec", K_VEC, 0, 1, 32'hFFC30);
        push_exp("fill busy_count", K_CNT, 0, 1, 32'd12);
        step(); idle(); bus.flush = 1'b1; disp(1, 9); rd(5, 1);
        push_exp("flush-cycle r5 busy", K_BUSY, 0, 0, 32'd1);
        push_exp("flush-cycle r5 tag", K_TAG, 0, 0, 32'd3);
        push_exp("flush-cycle r1 busy", K_BUSY, 1, 0, 32'd0);
        push_exp("flush busy_vec", K_VEC, 0, 1, 32'h0);
        push_exp("flush busy_count", K_CNT, 0, 1, 32'd0);
        step(); idle();
        push_exp("post-flush r1 busy", K_BUSY, 1, 0, 32'd0);

        // asynchronous reset mid-run
        step(); idle(); disp(3, 2); rd(3, 0);
        push_exp("r3 busy_vec", K_VEC, 0, 1, 32'h8);
        push_exp("r3 busy_count", K_CNT, 0, 1, 32'd1);
        step(); idle();
        push_exp("r3 lookup tag", K_TAG, 0, 0, 32'd2);
        step(); idle();
        rst_n = 1'b0;
        #1;
        push_exp("async reset busy_vec", K_VEC, 0, 0, 32'h0);
        push_exp("async reset busy_count", K_CNT, 0, 0, 32'd0);
        push_exp("async reset r3 busy", K_BUSY, 0, 0, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step(); idle(); disp(6, 1);
        push_exp("after reset busy_vec", K_VEC, 0, 1, 32'h40);
        push_exp("after reset busy_count", K_CNT, 0, 1, 32'd1);
        step(); idle();
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
